fifo_rd_packer: RTL and testbench

Read-side drain stage placed directly downstream of the asynchronous FIFO, in the read clock domain. It pops DSIZE-bit entries from the FIFO read port and packs LANES consecutive entries into one wide word. Each packed word is presented on a valid/ready output towards the wide datapath. Backpressure from the output stalls FIFO pops, so no entry is ever dropped or duplicated.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_rd_packer_tmo.sv | 53 +++++
 rtl/fifo_rd_packer.sv | 112 +++++++++++
 tb/tb_fifo_rd_packer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Definitions shared by the asynchronous FIFO and its read-side packer:
//   DSIZE_DEF / LANES_DEF : default entry width and packing factor.
//   MAX_LANES             : widest packing factor supported by the helpers.
//   cnt_width()           : bits needed for a counter holding 0..lanes.
//   keep_mask()           : lane-valid mask with the low n bits set.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int LANES_DEF = 4;
  localparam int MAX_LANES = 16;

  // A counter that must hold LANES itself, not just LANES-1.
  function automatic int cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  function automatic logic [MAX_LANES-1:0] keep_mask(input int n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_tmo.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_tmo
// Idle timer for the packer. Used only when FIFO_RD_PACKER_TIMEOUT_EN is
// defined. It counts cycles spent holding a partial word with no pop, and
// requests a flush once TMO idle cycles have elapsed and the slot is free.
// Ports:
//   i_rclk, i_rrst_n : clock, async active-low reset
//   cnt              : entries currently held by the accumulator
//   pop              : an entry is popped this cycle
//   slot_free        : output slot can take a word this cycle
//   flush            : load the partial word this cycle
// -----------------------------------------------------------------------------
module fifo_rd_packer_tmo
  import fifo_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int TMO   = 16,
  parameter int CW    = cnt_width(LANES)
) (
  input  logic          i_rclk,
  input  logic          i_rrst_n,
  input  logic [CW-1:0] cnt,
  input  logic          pop,
  input  logic          slot_free,
  output logic          flush
);

  localparam logic [CW-1:0] FULL   = CW'(LANES);
  localparam logic [7:0]    TMO_V  = 8'(TMO);
  localparam logic [7:0]    TMO_M1 = 8'(TMO - 1);

  logic [7:0] idle;
  logic       partial;
  logic       req;

  assign partial = (cnt != '0) && (cnt < FULL);
  // The current idle cycle counts toward TMO, so the request is raised while
  // the counter still reads TMO-1; this makes the word appear TMO+1 cycles
  // after the last pop.
  assign req   = partial && !pop && (idle >= TMO_M1);
  assign flush = req && slot_free;

  always_ff @(posedge i_rclk or negedge i_rrst_n) begin
    if (!i_rrst_n) begin
      idle <= '0;
    end else if (pop || flush) begin
      idle <= '0;
    end else if (partial && (idle < TMO_V)) begin
      idle <= idle + 8'd1;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Read-side drain for the async FIFO: pops DSIZE-bit entries (first-word
// fall-through) and packs LANES of them, lane 0 first, into one wide word
// offered on a valid/ready interface. A full accumulator with a busy output
// slot stops popping, so nothing is dropped or duplicated.
// Optional feature: define FIFO_RD_PACKER_TIMEOUT_EN to flush a partial word
// after TMO idle cycles (o_keep then marks the filled lanes).
// Ports:
//   i_rclk, i_rrst_n : read clock, async active-low reset
//   i_rempty, i_rdata: FIFO read face;  o_rd : pop strobe
//   o_valid, i_ready : output handshake
//   o_data, o_keep   : packed word and lane-valid mask
// -----------------------------------------------------------------------------
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int LANES = LANES_DEF,
  parameter int TMO   = 16
) (
  input  logic                   i_rclk,
  input  logic                   i_rrst_n,
  input  logic                   i_rempty,
  input  logic [DSIZE-1:0]       i_rdata,
  output logic                   o_rd,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DSIZE*LANES-1:0] o_data,
  output logic [LANES-1:0]       o_keep
);

  localparam int            CW       = cnt_width(LANES);
  localparam int            LW       = $clog2(LANES);
  localparam int            WW       = DSIZE * LANES;
  localparam logic [CW-1:0] FULL     = CW'(LANES);
  localparam logic [CW-1:0] LAST     = CW'(LANES - 1);
  localparam logic [LANES-1:0] KEEP_ALL = LANES'(keep_mask(LANES));

  logic [WW-1:0]    acc, acc_n;
  logic [CW-1:0]    cnt;
  logic [LW-1:0]    lane;
  logic             pop;
  logic             slot_free;
  logic             complete;
  logic             flush;
  logic             load;
  logic [LANES-1:0] load_keep;

  assign slot_free = !o_valid || i_ready;
  assign o_rd      = !i_rempty && (cnt < FULL);
  assign pop       = o_rd;
  assign lane      = cnt[LW-1:0];
  assign complete  = (cnt == FULL) || (pop && (cnt == LAST));

  // Accumulator as it will look after this cycle's pop; loading from here lets
  // the last lane go straight into the slot without an extra cycle.
  always_comb begin
    // NOTE: default first so every path assigns acc_n and no latch is inferred.
    acc_n = acc;
    if (pop) acc_n[int'(lane)*DSIZE +: DSIZE] = i_rdata;
  end

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  fifo_rd_packer_tmo #(
    .LANES (LANES),
    .TMO   (TMO),
    .CW    (CW)
  ) u_tmo (
    .i_rclk    (i_rclk),
    .i_rrst_n  (i_rrst_n),
    .cnt       (cnt),
    .pop       (pop),
    .slot_free (slot_free),
    .flush     (flush)
  );
  assign load_keep = flush ? LANES'(keep_mask(int'(cnt))) : KEEP_ALL;
`else
  assign flush     = 1'b0;
  assign load_keep = KEEP_ALL;
`endif

  // A flush only fires with no pop and a partial count, so it never overlaps
  // a completing word.
  assign load = (complete || flush) && slot_free;

  always_ff @(posedge i_rclk or negedge i_rrst_n) begin
    if (!i_rrst_n) begin
      // NOTE: acc is a register bank, not RAM, so it is reset; unused lanes of
      // a flushed word then read as zero without extra masking.
      acc     <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_keep  <= '0;
      o_data  <= '0;
    end else if (load) begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      o_data  <= acc_n;
      o_keep  <= load_keep;
      o_valid <= 1'b1;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (pop) begin
        acc <= acc_n;
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Directed bench for fifo_rd_packer (DSIZE=8, LANES=4, TMO=16). A queue models
// the FIFO read face; every pushed entry also feeds a packing model that
// queues the expected words, which are popped and compared on each accept.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

  localparam int DSIZE = 8;
  localparam int LANES = 4;
  localparam int TMO   = 16;

  logic                   i_rclk;
  logic                   i_rrst_n;
  logic                   i_rempty;
  logic [DSIZE-1:0]       i_rdata;
  logic                   o_rd;
  logic                   o_valid;
  logic                   i_ready;
  logic [DSIZE*LANES-1:0] o_data;
  logic [LANES-1:0]       o_keep;

  fifo_rd_packer #(
    .DSIZE (DSIZE),
    .LANES (LANES),
    .TMO   (TMO)
  ) dut (
    .i_rclk   (i_rclk),
    .i_rrst_n (i_rrst_n),
    .i_rempty (i_rempty),
    .i_rdata  (i_rdata),
    .o_rd     (o_rd),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_keep   (o_keep)
  );

  initial begin
    i_rclk = 1'b0;
    forever #5 i_rclk = ~i_rclk;
  end

  logic [7:0]  src[$];     // FIFO contents
  logic [7:0]  part[$];    // model partial word
  logic [35:0] exp_q[$];   // expected {keep, data}

  int checks = 0;
  int fails  = 0;
  int pops, accepts, valid_cycles, rd_viol, cyc;
  int last_pop_cyc, first_valid_cyc;
  bit gap_en, gap_phase;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] e);
    logic [31:0] w;
    src.push_back(e);
    part.push_back(e);
    if (part.size() == LANES) begin
      w = '0;
      for (int i = 0; i < LANES; i++) w[i*8 +: 8] = part[i];
      exp_q.push_back({4'hF, w});
      part.delete();
    end
  endtask

  // One clock cycle: drive the FIFO face, sample mid-cycle, advance the model.
  task automatic step();
    bit do_pop;
    i_rempty  = (gap_en && gap_phase) || (src.size() == 0);
    gap_phase = ~gap_phase;
    i_rdata   = (src.size() != 0) ? src[0] : 8'hEE;
    #1;
    cyc++;
    if (o_rd && i_rempty) rd_viol++;
    if (o_valid) begin
      valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (o_valid && i_ready) begin
      accepts++;
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("word", 64'({o_keep, o_data}), 64'(exp_q.pop_front()));
    end
    do_pop = o_rd && !i_rempty;
    if (do_pop) last_pop_cyc = cyc;
    @(posedge i_rclk);
    #1;
    if (do_pop) begin
      void'(src.pop_front());
      pops++;
    end
  endtask

  initial begin
    pops = 0; accepts = 0; valid_cycles = 0; rd_viol = 0; cyc = 0;
    last_pop_cyc = -1; first_valid_cyc = -1;
    gap_en = 1'b0; gap_phase = 1'b0;
    i_rrst_n = 1'b0; i_rempty = 1'b1; i_rdata = '0; i_ready = 1'b0;

    // Reset state
    #3;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_keep",  64'(o_keep),  64'd0);
    check("rst_data",  64'(o_data),  64'd0);
    check("rst_rd",    64'(o_rd),    64'd0);
    #10 i_rrst_n = 1'b1;
    @(posedge i_rclk); #1;

    // Steady stream: two words, one valid cycle each
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    valid_cycles = 0;
    repeat (14) step();
    check("steady_valid_cycles", 64'(valid_cycles), 64'd2);
    check("steady_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: 12 entries, slot held full
    i_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
    pops = 0;
    repeat (20) step();
    check("bp_pops", 64'(pops), 64'd8);
    check("bp_rd_low", 64'(o_rd), 64'd0);
    check("bp_hold_data", 64'(o_data), 64'h13121110);
    check("bp_hold_keep", 64'(o_keep), 64'hF);
    // Release: accept and load coincide, so o_valid stays high
    i_ready = 1'b1;
    accepts = 0;
    step();
    check("b2b_valid", 64'(o_valid), 64'd1);
    check("b2b_data", 64'(o_data), 64'h17161514);
    repeat (10) step();
    check("bp_accepts", 64'(accepts), 64'd3);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Empty gaps every other cycle
    gap_en = 1'b1;
    rd_viol = 0;
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    repeat (24) step();
    gap_en = 1'b0;
    check("gap_rd_while_empty", 64'(rd_viol), 64'd0);
    check("gap_src_empty", 64'(src.size()), 64'd0);
    check("gap_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-word: partial contents discarded
    pops = 0;
    push(8'h30); push(8'h31);
    repeat (4) step();
    check("mid_pops", 64'(pops), 64'd2);
    i_rrst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(o_valid), 64'd0);
    part.delete();
    #2 i_rrst_n = 1'b1;
    @(posedge i_rclk); #1;
    accepts = 0;
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    repeat (8) step();
    check("mid_accepts", 64'(accepts), 64'd1);
    check("mid_drained", 64'(exp_q.size()), 64'd0);

    // Partial word: flushed with the timeout, held forever without it
    push(8'h11); push(8'h22); push(8'h33);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    part.delete();
    exp_q.push_back({4'h7, 32'h00332211});
    first_valid_cyc = -1;
    repeat (30) step();
    check("tmo_latency", 64'(first_valid_cyc - last_pop_cyc), 64'd17);
    check("tmo_drained", 64'(exp_q.size()), 64'd0);
`else
    valid_cycles = 0;
    repeat (40) step();
    check("notmo_no_output", 64'(valid_cycles), 64'd0);
    push(8'h44);
    repeat (6) step();
    check("notmo_drained", 64'(exp_q.size()), 64'd0);
`endif

    check("rd_while_empty_total", 64'(rd_viol), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
